inversion_counter: RTL and testbench
====================================

Name: inversion_counter

Overview:
- Parametrised successor to the sort datapath's index counters (P1/P2 pair counters, 16-bit compare, +1 load register), wrapped in a controller.
- Walks every index pair (i, j) with i < j over the first `len` words of an external synchronous-read memory.
- Compares A[i] against A[j] and counts inversions (A[i] > A[j]).
- Sits beside the sort engine and supplies a sortedness metric and a self-check for the sorter.

Parameters:
DATA_W, 16, element width in bits
DEPTH, 256, maximum element count (≥2); ADDR_W = $clog2(DEPTH) and CNT_W = 2*ADDR_W are derived localparams, not overridable

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin a scan; sampled only in IDLE
len  in  ADDR_W+1  element count; latched when start is accepted
signed_mode  in  1  0 = unsigned compare, 1 = two's-complement compare; latched when start is accepted
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory read address
rd_data  in  DATA_W  read data; valid exactly one cycle after the rd_en cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at scan end
inv_count  out  CNT_W  inversion total; held stable from done until the next accepted start

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; i and j clear; a_i register clears.
  - inv_count = 0, rd_en = 0, rd_addr = 0, busy = 0, done = 0.
  - Reset during a scan abandons it; no done pulse is produced.
- Start acceptance (IDLE):
  - start=1 latches len_q = min(len, DEPTH) and signed_mode.
  - Clears inv_count, sets i = 0.
  - If len_q ≥ 2, go to RD_I. Otherwise go directly to DONE with inv_count = 0.
- RD_I: rd_en=1, rd_addr=i; next LAT_I.
- LAT_I: a_i <= rd_data; j <= i+1; next RD_J.
- RD_J: rd_en=1, rd_addr=j; next CMP.
- CMP:
  - If a_i > rd_data under the latched mode, inv_count <= inv_count + 1.
  - If j == len_q-1 and i == len_q-2, go to DONE.
  - If j == len_q-1 and i < len_q-2, set i <= i+1 and go to RD_I.
  - Otherwise set j <= j+1 and go to RD_J.
- DONE: done=1 for one cycle; next IDLE.
- Outside RD_I and RD_J: rd_en=0; rd_addr holds its last value.
- Latency:
  - Outer iteration i costs 2 + 2*(len_q-1-i) cycles.
  - DONE follows the final CMP directly.
  - len_q=4 gives 18 cycles of RD_I/LAT_I/RD_J/CMP, with done in the 19th cycle after the accepting edge.
- Width and arithmetic rules:
  - Equal values are not inversions.
  - inv_count cannot overflow: the maximum is DEPTH*(DEPTH-1)/2 < 2^CNT_W.
  - The i and j comparisons against len_q-1 and len_q-2 are done at ADDR_W+1 bits, so no wrap at len_q = DEPTH.
- Simultaneous and boundary events:
  - start while busy is ignored; len and signed_mode changes while busy are ignored.
  - start in the same cycle as rst=0 is ignored; reset wins.
  - len=0 or len=1 produces done one cycle after start, with count 0.
  - len > DEPTH is clamped to DEPTH.

Decomposition:
- Shared package ic_pkg:
  - state enum {IDLE, RD_I, LAT_I, RD_J, CMP, DONE}
  - mode constants CMP_UNSIGNED = 1'b0, CMP_SIGNED = 1'b1
- One sub-module, pair_index_counter (parameter ADDR_W):
  - Outputs i, j, last_j, last_pair.
  - Inputs init, step_j, step_i and len_q.
  - step_i loads j <= i+2 alongside i <= i+1. This generalises the P1/P2 pair.
- Top level holds the FSM, the a_i register, the comparator and inv_count.

Test Plan:
- Unsigned basic: memory [3,1,2,0], len=4, mode=0, start → inv_count=5.
  - done exactly 19 cycles after the accepting edge.
  - Read addresses in order 0,1,2,3,1,2,3,2,3.
- Signed vs unsigned: memory [0x0001,0xFFFF], len=2.
  - mode=0 → inv_count=0.
  - mode=1 → inv_count=1.
- Degenerate lengths:
  - len=1 → done on the cycle after start, inv_count=0, rd_en never asserted.
  - len=0 → same response.
- Full depth: DEPTH=8, memory [7..0] descending, len=8 (and len=12, clamped) → inv_count=28; sorted ascending → 0; all-equal → 0.
- Reset and busy: assert rst=0 mid-scan → next cycle busy=0, inv_count=0, no done.
  - start pulsed while busy → ignored; count equals the single-scan value.
- Hold behaviour: after done, toggle len and mode and change memory without start → inv_count unchanged.
  - New start clears it to 0 on the accepting edge.

Source files
------------

// File: rtl/inversion_counter_pkg.sv
// Shared definitions for the inversion counter slice.
//   state_t      : controller states
//   CMP_UNSIGNED : signed_mode value selecting an unsigned compare
//   CMP_SIGNED   : signed_mode value selecting a two's-complement compare
package ic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        CMP,
        DONE
    } state_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/inversion_counter_if.sv
// Control and memory-read bus of the inversion counter.
//   start, len, signed_mode : scan request (requester -> counter)
//   rd_en, rd_addr          : memory read strobe/address (counter -> memory)
//   rd_data                 : read data, one cycle after rd_en (memory -> counter)
//   busy, done, inv_count   : status and result (counter -> requester)
// slave is the counter's view; master is the requester/memory view.
interface inversion_counter_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = 2 * ADDR_W;

    logic              start;
    logic [ADDR_W:0]   len;
    logic              signed_mode;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  inv_count;

    modport slave (
        input  start, len, signed_mode, rd_data,
        output rd_en, rd_addr, busy, done, inv_count
    );

    modport master (
        output start, len, signed_mode, rd_data,
        input  rd_en, rd_addr, busy, done, inv_count
    );
endinterface

// File: rtl/inversion_counter_pair_index_counter.sv
// Index pair generator (i, j) with i < j over the first len_q elements.
//   clk, rst  : clock, synchronous active-low reset
//   init      : i <= 0, j <= 1 (start of a scan)
//   step_j    : j <= j + 1 (next partner for the same i)
//   step_i    : i <= i + 1, j <= i + 2 (next outer element, j just after it)
//   len_q     : latched element count (ADDR_W+1 bits)
//   i, j      : current pair
//   last_j    : j is the final element
//   last_pair : (i, j) is the final pair of the scan
module pair_index_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step_i,
    input  logic              step_j,
    input  logic [ADDR_W:0]   len_q,
    output logic [ADDR_W-1:0] i,
    output logic [ADDR_W-1:0] j,
    output logic              last_j,
    output logic              last_pair
);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO = (ADDR_W+1)'(2);

    // Compared one bit wider than the indices so len_q == DEPTH does not wrap.
    assign last_j    = ({1'b0, j} == (len_q - ONE));
    assign last_pair = last_j && ({1'b0, i} == (len_q - TWO));

    always_ff @(posedge clk) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
        end else if (init) begin
            i <= '0;
            j <= ADDR_W'(1);
        end else if (step_i) begin
            i <= i + ADDR_W'(1);
            j <= i + ADDR_W'(2);
        end else if (step_j) begin
            j <= j + ADDR_W'(1);
        end
    end
endmodule

// File: rtl/inversion_counter.sv
// Counts inversions (A[i] > A[j], i < j) over the first len words of an
// external synchronous-read memory.
//   clk, rst : clock, synchronous active-low reset
//   bus      : inversion_counter_if.slave -- start/len/signed_mode request,
//              rd_en/rd_addr/rd_data memory port, busy/done/inv_count status
module inversion_counter
    import ic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input logic               clk,
    input logic               rst,
    inversion_counter_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = 2 * ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_clamp;
    logic              mode_q;
    logic [DATA_W-1:0] a_i_q;
    logic [CNT_W-1:0]  inv_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, i, j;
    logic              init, step_i, step_j, last_j, last_pair, inv_hit;

    // j is already i+1 when LAT_I runs: init and step_i both leave it there.
    pair_index_counter #(.ADDR_W(ADDR_W)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .step_i   (step_i),
        .step_j   (step_j),
        .len_q    (len_q),
        .i        (i),
        .j        (j),
        .last_j   (last_j),
        .last_pair(last_pair)
    );

    assign len_clamp = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    assign inv_hit   = (mode_q == CMP_SIGNED) ? ($signed(a_i_q) > $signed(bus.rd_data))
                                              : (a_i_q > bus.rd_data);

    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        step_i  = 1'b0;
        step_j  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                init    = 1'b1;
                state_d = (len_clamp >= (ADDR_W+1)'(2)) ? RD_I : DONE;
            end
            RD_I:  state_d = LAT_I;
            LAT_I: state_d = RD_J;
            RD_J:  state_d = CMP;
            CMP: begin
                if (last_pair) begin
                    state_d = DONE;
                end else if (last_j) begin
                    step_i  = 1'b1;
                    state_d = RD_I;
                end else begin
                    step_j  = 1'b1;
                    state_d = RD_J;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address follows the index directly in the read states, otherwise holds.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (state_q == RD_I) rd_addr_d = i;
        if (state_q == RD_J) rd_addr_d = j;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            mode_q    <= CMP_UNSIGNED;
            a_i_q     <= '0;
            inv_q     <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            if (state_q == IDLE && bus.start) begin
                len_q  <= len_clamp;
                mode_q <= bus.signed_mode;
                inv_q  <= '0;
            end
            if (state_q == LAT_I) a_i_q <= bus.rd_data;
            if (state_q == CMP && inv_hit) inv_q <= inv_q + CNT_W'(1);
        end
    end

    assign bus.rd_en     = (state_q == RD_I) || (state_q == RD_J);
    assign bus.rd_addr   = rd_addr_d;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.inv_count = inv_q;
endmodule

// File: tb/tb_inversion_counter.sv
module tb_inversion_counter;
    import ic_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    inversion_counter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    inversion_counter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [8];
    int          addr_q [$];

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    typedef struct {
        logic [15:0] w [8];
        logic [3:0]  l;
        logic        m;
        int          exp_cnt;
        int          exp_cyc;
        int          exp_rd;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: count inversions straight from the definition.
    function automatic int ref_inv(input int l, input logic m);
        int n = (l > DEPTH) ? DEPTH : l;
        int c = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (m ? ($signed(mem[a]) > $signed(mem[b])) : (mem[a] > mem[b])) c++;
        return c;
    endfunction

    function automatic int ref_cyc(input int l);
        int n = (l > DEPTH) ? DEPTH : l;
        int c = 1;
        if (n < 2) return 1;
        for (int a = 0; a <= n - 2; a++) c += 2 + 2 * (n - 1 - a);
        return c;
    endfunction

    function automatic int ref_rd(input int l);
        int n = (l > DEPTH) ? DEPTH : l;
        return (n < 2) ? 0 : (n - 1) + n * (n - 1) / 2;
    endfunction

    task automatic start_only(input logic [3:0] l, input logic m);
        @(negedge clk);
        bus.len = l; bus.signed_mode = m; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Start a scan and follow it to done; poke>0 pulses a conflicting start mid-scan.
    task automatic run_scan(input logic [3:0] l, input logic m, input int poke,
                            output int cnt, output int cyc, output int nrd);
        start_only(l, m);
        cyc = 0; nrd = 0; addr_q.delete();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (bus.rd_en) begin nrd++; addr_q.push_back(int'(bus.rd_addr)); end
            if (bus.done) begin cyc = k; break; end
            if (poke > 0 && k == poke) begin
                bus.start = 1'b1; bus.len = 4'd8; bus.signed_mode = ~m;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (cyc == 0) chk("done_timeout", 0, 1);
        cnt = int'(bus.inv_count);
    endtask

    initial begin
        int cnt, cyc, nrd, dn;
        int exp_addr [9];
        logic [3:0] rl;
        logic       rm;

        exp_addr = '{0, 1, 2, 3, 1, 2, 3, 2, 3};
        tv[0]  = '{'{16'h3, 16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd4, 1'b0, 5, 19, 9};
        tv[1]  = '{'{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd2, 1'b0, 0, 5, 2};
        tv[2]  = '{'{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd2, 1'b1, 1, 5, 2};
        tv[3]  = '{'{16'h3, 16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd1, 1'b0, 0, 1, 0};
        tv[4]  = '{'{16'h3, 16'h1, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd0, 1'b0, 0, 1, 0};
        tv[5]  = '{'{16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1, 16'h0}, 4'd8, 1'b0, 28, 71, 35};
        tv[6]  = '{'{16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1, 16'h0}, 4'd12, 1'b0, 28, 71, 35};
        tv[7]  = '{'{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7}, 4'd8, 1'b1, 0, 71, 35};
        tv[8]  = '{'{16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h5}, 4'd8, 1'b0, 0, 71, 35};
        tv[9]  = '{'{16'hFFFF, 16'hFFFE, 16'h0, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd4, 1'b1, 1, 19, 9};
        tv[10] = '{'{16'hFFFF, 16'hFFFE, 16'h0, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0}, 4'd4, 1'b0, 5, 19, 9};

        rst = 1'b0; bus.start = 1'b0; bus.len = '0; bus.signed_mode = CMP_UNSIGNED;
        for (int k = 0; k < 8; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_rd_addr", bus.rd_addr, 0);
        chk("reset_inv_count", bus.inv_count, 0);
        rst = 1'b1;

        // Table-driven vectors
        for (int t = 0; t < 11; t++) begin
            for (int k = 0; k < 8; k++) mem[k] = tv[t].w[k];
            run_scan(tv[t].l, tv[t].m, 0, cnt, cyc, nrd);
            chk($sformatf("vec%0d_count", t), cnt, tv[t].exp_cnt);
            chk($sformatf("vec%0d_done_cycle", t), cyc, tv[t].exp_cyc);
            chk($sformatf("vec%0d_reads", t), nrd, tv[t].exp_rd);
            if (t == 0) begin
                chk("vec0_addr_len", addr_q.size(), 9);
                for (int k = 0; k < 9 && k < addr_q.size(); k++)
                    chk($sformatf("vec0_addr%0d", k), addr_q[k], exp_addr[k]);
            end
        end

        // Randomized scans against the reference model
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 8; k++)
                mem[k] = (t % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            rl = 4'($urandom_range(0, 15));
            rm = 1'($urandom);
            run_scan(rl, rm, 0, cnt, cyc, nrd);
            chk($sformatf("rnd%0d_count", t), cnt, ref_inv(int'(rl), rm));
            chk($sformatf("rnd%0d_done_cycle", t), cyc, ref_cyc(int'(rl)));
            chk($sformatf("rnd%0d_reads", t), nrd, ref_rd(int'(rl)));
        end

        // Start while busy is ignored
        for (int k = 0; k < 8; k++) mem[k] = 16'(7 - k);
        run_scan(4'd4, CMP_UNSIGNED, 3, cnt, cyc, nrd);
        chk("busy_start_count", cnt, 6);
        chk("busy_start_cycle", cyc, 19);

        // Hold after done
        run_scan(4'd8, CMP_UNSIGNED, 0, cnt, cyc, nrd);
        chk("hold_pre_count", cnt, 28);
        bus.len = 4'd3; bus.signed_mode = CMP_SIGNED;
        for (int k = 0; k < 8; k++) mem[k] = '0;
        repeat (10) @(negedge clk);
        chk("hold_count", bus.inv_count, 28);
        chk("hold_busy", bus.busy, 0);
        start_only(4'd3, CMP_SIGNED);
        chk("restart_clear", bus.inv_count, 0);
        chk("restart_busy", bus.busy, 1);
        dn = 0;
        for (int k = 0; k < 100 && dn == 0; k++) begin
            @(negedge clk);
            if (bus.done) dn = 1;
        end
        chk("restart_done_seen", dn, 1);
        chk("restart_count", bus.inv_count, 0);

        // Reset mid-scan abandons it
        for (int k = 0; k < 8; k++) mem[k] = 16'(7 - k);
        @(negedge clk);
        start_only(4'd8, CMP_UNSIGNED);
        repeat (10) @(negedge clk);
        chk("midscan_busy", bus.busy, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan_reset_busy", bus.busy, 0);
        chk("midscan_reset_count", bus.inv_count, 0);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("midscan_no_done", dn, 0);

        // Start coincident with reset is dropped
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b1; bus.len = 4'd8;
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        @(negedge clk);
        chk("rst_start_busy_after", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
